// File: rtl/uart_rx_oversampled_if.sv
// Receive-side handshake bundle for uart_rx_oversampled: held frame, status and
// consumer ready. The receiver drives through master, the consumer through slave.
`timescale 1ns/1ps
interface uart_rx_oversampled_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with 3-sample majority vote and a one-entry holding register.
// Define UART_RX_ERR_CNT_EN to add saturating parity/framing/overrun error counters.
`timescale 1ns/1ps
module uart_rx_oversampled #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 rx,
  uart_rx_oversampled_if.master rx_if,
  output logic                 busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]           par_err_cnt,
  output logic [7:0]           frm_err_cnt,
  output logic [7:0]           ovr_err_cnt
`endif
);
  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int B_W = $clog2(DATA_WIDTH + 1);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_V0   = S_W'(M - 1);
  localparam logic [S_W-1:0] S_V1   = S_W'(M);
  localparam logic [S_W-1:0] S_V2   = S_W'(M + 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK} state_t;

  state_t                state_q, state_d;
  logic                  rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_d_q, rx_d_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [1:0]            vote_q, vote_d;
  logic [B_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_acc_q, par_acc_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  stop2_q, stop2_d;
  logic                  cfg_par_en_q, cfg_par_en_d, cfg_par_odd_q, cfg_par_odd_d;
  logic                  cfg_two_stop_q, cfg_two_stop_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                  fall, tick, resolve, bit_val, deliver;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            par_cnt_q, par_cnt_d, frm_cnt_q, frm_cnt_d, ovr_cnt_q, ovr_cnt_d;
`endif

  always_comb begin
    state_d        = state_q;
    rx_s1_d        = rx;
    rx_s2_d        = rx_s1_q;
    rx_d_d         = rx_s2_q;
    div_cnt_d      = div_cnt_q;
    s_d            = s_q;
    vote_d         = vote_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    par_acc_d      = par_acc_q;
    perr_d         = perr_q;
    ferr_d         = ferr_q;
    stop2_d        = stop2_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_odd_d  = cfg_par_odd_q;
    cfg_two_stop_d = cfg_two_stop_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    parity_err_d   = parity_err_q;
    frame_err_d    = frame_err_q;
    overrun_d      = 1'b0;

    fall    = rx_d_q & ~rx_s2_q;
    tick    = (div_cnt_q == '0);
    resolve = tick && (s_q == S_V2);
    bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s2_q) | (vote_q[1] & rx_s2_q);
    deliver = (state_q == DELIVER);

    // Start detection reloads the divider and sample counter so bit timing aligns to the edge.
    if ((state_q == IDLE && fall) || tick) div_cnt_d = baud_div;
    else                                   div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
    if (state_q == IDLE && fall) s_d = '0;
    else if (tick)               s_d = (s_q == S_LAST) ? '0 : s_q + S_W'(1);
    if (tick && s_q == S_V0) vote_d[0] = rx_s2_q;
    if (tick && s_q == S_V1) vote_d[1] = rx_s2_q;

    case (state_q)
      IDLE: if (fall) begin
        state_d        = START;
        cfg_par_en_d   = parity_en;
        cfg_par_odd_d  = parity_odd;
        cfg_two_stop_d = two_stop;
        bit_cnt_d      = '0;
        par_acc_d      = 1'b0;
        perr_d         = 1'b0;
        ferr_d         = 1'b0;
        stop2_d        = 1'b0;
      end
      START: if (resolve) state_d = bit_val ? IDLE : DATA;
      DATA: if (resolve) begin
        shreg_d   = {bit_val, shreg_q[DATA_WIDTH-1:1]};
        par_acc_d = par_acc_q ^ bit_val;
        bit_cnt_d = bit_cnt_q + B_W'(1);
        if (bit_cnt_q == B_LAST) state_d = cfg_par_en_q ? PARITY : STOP;
      end
      PARITY: if (resolve) begin
        perr_d  = ((par_acc_q ^ bit_val) != cfg_par_odd_q);
        state_d = STOP;
      end
      STOP: if (resolve) begin
        if (!bit_val) ferr_d = 1'b1;
        if (cfg_two_stop_q && !stop2_q) stop2_d = 1'b1;
        else                            state_d = DELIVER;
      end
      DELIVER: state_d = ferr_q ? BREAK : IDLE;
      BREAK:   if (rx_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end

`ifdef UART_RX_ERR_CNT_EN
    par_cnt_d = par_cnt_q;
    frm_cnt_d = frm_cnt_q;
    ovr_cnt_d = ovr_cnt_q;
    if (deliver && perr_q && par_cnt_q != 8'hFF) par_cnt_d = par_cnt_q + 8'd1;
    if (deliver && ferr_q && frm_cnt_q != 8'hFF) frm_cnt_d = frm_cnt_q + 8'd1;
    if (overrun_q && ovr_cnt_q != 8'hFF)         ovr_cnt_d = ovr_cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_d_q         <= 1'b1;
      div_cnt_q      <= '0;
      s_q            <= '0;
      vote_q         <= '0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      par_acc_q      <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      stop2_q        <= 1'b0;
      cfg_par_en_q   <= 1'b0;
      cfg_par_odd_q  <= 1'b0;
      cfg_two_stop_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
      par_cnt_q      <= '0;
      frm_cnt_q      <= '0;
      ovr_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rx_s1_q        <= rx_s1_d;
      rx_s2_q        <= rx_s2_d;
      rx_d_q         <= rx_d_d;
      div_cnt_q      <= div_cnt_d;
      s_q            <= s_d;
      vote_q         <= vote_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      par_acc_q      <= par_acc_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      stop2_q        <= stop2_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_odd_q  <= cfg_par_odd_d;
      cfg_two_stop_q <= cfg_two_stop_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      parity_err_q   <= parity_err_d;
      frame_err_q    <= frame_err_d;
      overrun_q      <= overrun_d;
`ifdef UART_RX_ERR_CNT_EN
      par_cnt_q      <= par_cnt_d;
      frm_cnt_q      <= frm_cnt_d;
      ovr_cnt_q      <= ovr_cnt_d;
`endif
    end
  end

  assign rx_if.rx_data     = rx_data_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.parity_err  = parity_err_q;
  assign rx_if.frame_err   = frame_err_q;
  assign rx_if.overrun_err = overrun_q;
  assign busy              = (state_q != IDLE);
`ifdef UART_RX_ERR_CNT_EN
  assign par_err_cnt = par_cnt_q;
  assign frm_err_cnt = frm_cnt_q;
  assign ovr_err_cnt = ovr_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: an 8-bit x16 instance and a 5-bit x13 instance.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bd8, bd5;
  logic        pen8, podd8, ts8, rx8, busy8;
  logic        pen5, podd5, ts5, rx5, busy5;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned ovr_seen8 = 0;
  int unsigned ovr_seen5 = 0;
  exp_t        q8[$];
  exp_t        q5[$];

  uart_rx_oversampled_if #(.DATA_WIDTH(8)) if8 ();
  uart_rx_oversampled_if #(.DATA_WIDTH(5)) if5 ();

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] pcnt8, fcnt8, ocnt8, pcnt5, fcnt5, ocnt5;
`endif

  uart_rx_oversampled #(.DATA_WIDTH(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .baud_div(bd8), .parity_en(pen8), .parity_odd(podd8),
    .two_stop(ts8), .rx(rx8), .rx_if(if8.master), .busy(busy8)
`ifdef UART_RX_ERR_CNT_EN
    , .par_err_cnt(pcnt8), .frm_err_cnt(fcnt8), .ovr_err_cnt(ocnt8)
`endif
  );

  uart_rx_oversampled #(.DATA_WIDTH(5), .OVERSAMPLE(13), .DIV_WIDTH(16)) dut5 (
    .clk(clk), .reset(reset), .baud_div(bd5), .parity_en(pen5), .parity_odd(podd5),
    .two_stop(ts5), .rx(rx5), .rx_if(if5.master), .busy(busy5)
`ifdef UART_RX_ERR_CNT_EN
    , .par_err_cnt(pcnt5), .frm_err_cnt(fcnt5), .ovr_err_cnt(ocnt5)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every accepted frame, count overrun pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (if8.rx_valid && if8.rx_ready) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious8: got data %0h expected no frame", if8.rx_data);
        end else begin
          e = q8.pop_front();
          check("data8", {23'd0, 1'b0, if8.rx_data}, {23'd0, e.d});
          check("perr8", {31'd0, if8.parity_err}, {31'd0, e.pe});
          check("ferr8", {31'd0, if8.frame_err}, {31'd0, e.fe});
        end
      end
      if (if5.rx_valid && if5.rx_ready) begin
        if (q5.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious5: got data %0h expected no frame", if5.rx_data);
        end else begin
          e = q5.pop_front();
          check("data5", {27'd0, if5.rx_data}, {23'd0, e.d});
          check("perr5", {31'd0, if5.parity_err}, {31'd0, e.pe});
          check("ferr5", {31'd0, if5.frame_err}, {31'd0, e.fe});
        end
      end
      if (if8.overrun_err) ovr_seen8++;
      if (if5.overrun_err) ovr_seen5++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic line8(input logic v, input int unsigned n);
    rx8 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line5(input logic v, input int unsigned n);
    rx5 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic use_par, input logic pbit, input logic stopv);
    line8(1'b0, 64);
    for (int i = 0; i < 8; i++) line8(d[i], 64);
    if (use_par) line8(pbit, 64);
    line8(stopv, 64);
  endtask

  task automatic send5(input logic [4:0] d, input logic s1, input logic s2);
    line5(1'b0, 13);
    for (int i = 0; i < 5; i++) line5(d[i], 13);
    line5(s1, 13);
    line5(s2, 13);
  endtask

  task automatic push8(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = {1'b0, d}; e.pe = pe; e.fe = fe;
    q8.push_back(e);
  endtask

  task automatic push5(input logic [4:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = {4'd0, d}; e.pe = pe; e.fe = fe;
    q5.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    bd8 = 16'd3; pen8 = 1'b0; podd8 = 1'b0; ts8 = 1'b0; rx8 = 1'b1; if8.rx_ready = 1'b1;
    bd5 = 16'd0; pen5 = 1'b0; podd5 = 1'b0; ts5 = 1'b1; rx5 = 1'b1; if5.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", {31'd0, if8.rx_valid}, 32'd0);
    check("rst_data", {24'd0, if8.rx_data}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_err", {29'd0, if8.parity_err, if8.frame_err, if8.overrun_err}, 32'd0);
    line8(1'b1, 10);

    push8(8'hA5, 1'b0, 1'b0);
    send8(8'hA5, 1'b0, 1'b0, 1'b1);
    line8(1'b1, 20);
    check("valid_one_cycle", {31'd0, if8.rx_valid}, 32'd0);

    pen8 = 1'b1; podd8 = 1'b0;
    push8(8'h07, 1'b0, 1'b0);
    send8(8'h07, 1'b1, 1'b1, 1'b1);
    line8(1'b1, 20);
    push8(8'h07, 1'b1, 1'b0);
    send8(8'h07, 1'b1, 1'b0, 1'b1);
    line8(1'b1, 20);
    pen8 = 1'b0;

    push8(8'h3C, 1'b0, 1'b1);
    send8(8'h3C, 1'b0, 1'b0, 1'b0);
    line8(1'b0, 200);
    check("break_busy", {31'd0, busy8}, 32'd1);
    line8(1'b1, 6);
    check("break_exit", {31'd0, busy8}, 32'd0);
    line8(1'b1, 60);
    push8(8'h11, 1'b0, 1'b0);
    send8(8'h11, 1'b0, 1'b0, 1'b1);
    line8(1'b1, 20);

    line8(1'b0, 10);
    check("glitch_busy", {31'd0, busy8}, 32'd1);
    line8(1'b0, 10);
    line8(1'b1, 100);
    check("glitch_idle", {31'd0, busy8}, 32'd0);
    check("glitch_novalid", {31'd0, if8.rx_valid}, 32'd0);

    if8.rx_ready = 1'b0;
    push8(8'h12, 1'b0, 1'b0);
    send8(8'h12, 1'b0, 1'b0, 1'b1);
    send8(8'h34, 1'b0, 1'b0, 1'b1);
    line8(1'b1, 50);
    check("ovr_count", ovr_seen8, 32'd1);
    check("ovr_hold_data", {24'd0, if8.rx_data}, 32'h12);
    check("ovr_hold_valid", {31'd0, if8.rx_valid}, 32'd1);
    // DELIVER for a frame starting now falls in the cycle after the 619th posedge.
    push8(8'h56, 1'b0, 1'b0);
    fork
      send8(8'h56, 1'b0, 1'b0, 1'b1);
      begin
        repeat (619) @(posedge clk);
        #1 if8.rx_ready = 1'b1;
        @(posedge clk);
        #1 if8.rx_ready = 1'b0;
      end
    join
    line8(1'b1, 50);
    check("accept_deliver_ovr", ovr_seen8, 32'd1);
    check("accept_deliver_data", {24'd0, if8.rx_data}, 32'h56);
    check("accept_deliver_valid", {31'd0, if8.rx_valid}, 32'd1);
    if8.rx_ready = 1'b1;
    line8(1'b1, 5);
    check("drain_valid", {31'd0, if8.rx_valid}, 32'd0);

`ifdef UART_RX_ERR_CNT_EN
    check("par_cnt", {24'd0, pcnt8}, 32'd1);
    check("frm_cnt", {24'd0, fcnt8}, 32'd1);
    check("ovr_cnt", {24'd0, ocnt8}, 32'd1);
`endif

    line8(1'b0, 64);
    line8(1'b1, 64);
    line8(1'b0, 30);
    reset = 1'b1;
    line8(1'b0, 2);
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_valid", {31'd0, if8.rx_valid}, 32'd0);
    check("midrst_data", {24'd0, if8.rx_data}, 32'd0);
    check("midrst_err", {29'd0, if8.parity_err, if8.frame_err, if8.overrun_err}, 32'd0);
    reset = 1'b0;
    line8(1'b1, 800);
    check("midrst_idle", {31'd0, busy8}, 32'd0);
    check("midrst_noframe", {31'd0, if8.rx_valid}, 32'd0);

    push5(5'h1B, 1'b0, 1'b0);
    send5(5'h1B, 1'b1, 1'b1);
    line5(1'b1, 20);
    push5(5'h0A, 1'b0, 1'b1);
    send5(5'h0A, 1'b1, 1'b0);
    check("x13_break_busy", {31'd0, busy5}, 32'd1);
    line5(1'b1, 10);
    check("x13_break_exit", {31'd0, busy5}, 32'd0);
    check("x13_ovr", ovr_seen5, 32'd0);

    line5(1'b1, 10);
    check("q8_drained", q8.size(), 32'd0);
    check("q5_drained", q5.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Parametrised UART receiver, the successor to the fixed 5-bit receive path. It supports run-time baud divisor, data width, oversampling ratio (13 or 16), optional even/odd parity and 1 or 2 stop bits. Incoming data is recovered by 3-sample majority vote around mid-bit. Each frame is delivered through a one-entry valid/ready holding register with per-frame parity, framing and overrun status. It sits between the serial rx pin and the bus-side RX FIFO/register block.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
OVERSAMPLE, 16, ticks per bit; legal 13 or 16 (X13/X16).
DIV_WIDTH, 16, width of baud_div.

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
baud_div  in  DIV_WIDTH  clk cycles per oversample tick minus 1
parity_en  in  1  1 = parity bit present
parity_odd  in  1  1 = odd parity, 0 = even; ignored if parity_en=0
two_stop  in  1  1 = two stop bits checked
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_WIDTH  received word, LSB first on the line
rx_valid  out  1  rx_data and status valid
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the held frame; qualified by rx_valid
frame_err  out  1  a stop bit sampled 0 for the held frame; qualified by rx_valid
overrun_err  out  1  one-cycle pulse: completed frame dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: clock and reset are as stated under Ports. Outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0. Synchroniser flops=1. FSM=IDLE. Counters=0. Reset mid-frame abandons the frame; no output is produced.
- Input path: 2-flop synchroniser on rx, plus a 1-flop delayed copy for falling-edge detect.
- Tick generator: down-counter loaded with baud_div; emits a one-cycle tick when it reaches 0, then reloads. It is forced to reload on start detection so that bit timing aligns to the edge. baud_div=0 gives a tick every cycle.
- Sample counter s runs 0..OVERSAMPLE-1 per bit and advances on tick. Votes are taken at s=M-1, M and M+1, where M=OVERSAMPLE/2. The bit value is the majority of the 3 votes and is resolved at s=M+1.
- Config (parity_en, parity_odd, two_stop) is latched at start detection. Changes mid-frame have no effect.
- FSM:
  - IDLE: on synchronised falling edge -> START; latch config.
  - START: at bit resolve, vote=1 -> IDLE (false start, no output); vote=0 -> DATA.
  - DATA: shift in LSB first. After DATA_WIDTH bits -> PARITY if parity_en, else STOP.
  - PARITY: error if the XOR of the data bits and the parity bit is not equal to parity_odd. Then -> STOP.
  - STOP: resolve the stop bit; 0 sets the frame error. If two_stop and first stop -> STOP (second bit). Otherwise -> DELIVER.
  - DELIVER (1 cycle): load the holding register. If the frame error is set -> BREAK, else -> IDLE.
  - BREAK: wait until synchronised rx=1, then -> IDLE.
- Return to IDLE happens mid-stop-bit, so a back-to-back start edge is detected.
- Holding register:
  - In DELIVER, if !rx_valid or rx_ready: load rx_data, parity_err and frame_err; rx_valid=1 next cycle.
  - If rx_valid && !rx_ready: the new frame is dropped, the old frame is kept, and overrun_err pulses 1 cycle.
  - Same-cycle accept and DELIVER: the old frame is consumed and the new one loaded, with no overrun.
  - Accept with no DELIVER: rx_valid=0 next cycle.
- Latency: rx_valid rises 2 cycles after the tick at which the last stop bit resolves (1 cycle in DELIVER, then registered).

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined:
  - Adds outputs par_err_cnt, frm_err_cnt and ovr_err_cnt, each 8 bits.
  - Each counter saturates at 255 and is cleared only by reset.
  - par_err_cnt and frm_err_cnt increment on DELIVER with the respective error set, counted even if the frame is dropped.
  - ovr_err_cnt increments on each overrun_err pulse.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- DATA_WIDTH=8, OVERSAMPLE=16, baud_div=3 (64 clk/bit), no parity, 1 stop; send 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high 1 cycle, parity_err=0, frame_err=0.
- Same setup, parity_en=1, parity_odd=0; send 0x07 with parity bit 1 -> parity_err=0. Send 0x07 with parity bit 0 -> rx_valid with parity_err=1.
- 0x3C with stop bit forced 0, then line held low 200 clk -> frame_err=1, busy stays 1 until rx returns high. Next frame 0x11 is received cleanly.
- rx_ready=0; send 0x12 then 0x34 back-to-back -> rx_data holds 0x12 and overrun_err pulses once. Assert rx_ready on the exact DELIVER cycle of a third frame 0x56 -> 0x56 is loaded with no overrun.
- Low glitch of 20 clk (<M ticks) on an idle line -> START rejects it, no rx_valid, busy returns to 0. Separately, assert reset mid-DATA -> all outputs 0 and no frame delivered.
- OVERSAMPLE=13, DATA_WIDTH=5, baud_div=0, two_stop=1; send 0x1B -> rx_data=5'h1B. Second stop driven 0 -> frame_err=1.
